regfile_decoded: RTL and testbench
==================================

Name: regfile_decoded

Overview:
- Parametrised register file for the single-cycle MIPS datapath: one write port and two asynchronous read ports.
- Write enables are generated by an N-to-2^N one-hot decoder with enable. This generalises the fixed 5-to-32 decode to any address width.
- Adds a zero register, registered write-enable visibility and optional same-cycle write-to-read forwarding.
- Sits between instruction decode (rs/rt/rd fields) and the ALU/writeback mux.

Parameters:
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W.
- DATA_W, 32, register data width.
- ZERO_REG_EN, 1, when 1 register 0 reads as 0 and ignores writes; when 0 it is an ordinary register.

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  write enable for the current cycle.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- raddr_a  in  ADDR_W  read address, port A (rs).
- raddr_b  in  ADDR_W  read address, port B (rt).
- rdata_a  out  DATA_W  read data, port A.
- rdata_b  out  DATA_W  read data, port B.
- wr_onehot_q  out  NUM_REGS  registered one-hot of the last accepted write; all zeros if none.
- wr_count_q  out  16  saturating count of accepted writes.

Behaviour:
- Reset (async assert, sync release by the system):
  - all registers = 0.
  - wr_onehot_q = 0; wr_count_q = 0.
  - rdata_a/rdata_b are combinational from the cleared array, so 0.
- Write decode: onehot = decode(waddr) gated by we. The en input of the decoder is we. Exactly one bit is set when we=1; all bits are 0 when we=0.
- Accepted write = we & !(ZERO_REG_EN & waddr==0).
  - On the rising edge of clk with an accepted write: reg[waddr] <= wdata.
  - Write latency is 1 cycle. The new value is visible on the read ports in the cycle after the edge.
- wr_onehot_q <= onehot masked by "accepted" every clock edge. A cycle with no accepted write clears it to 0.
- wr_count_q increments by 1 per accepted write and saturates at 16'hFFFF; it does not wrap.
- Reads are combinational, with zero-cycle latency from raddr_x to rdata_x.
  - If ZERO_REG_EN and raddr_x==0, rdata_x = 0 regardless of array contents.
- Same-address, same-cycle read and write:
  - Without bypass, the read returns the old value.
  - With bypass, see Optional Feature.
- Both read ports may address the same register, each returning identical data.
- Write to address 0 with ZERO_REG_EN=1: array unchanged, wr_onehot_q=0, counter unchanged.
- Reset asserted mid-write: reset wins. The array and status are cleared and the write is lost.
- X on waddr while we=0 must not corrupt any register.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if an accepted write is in progress this cycle and raddr_x==waddr, rdata_x = wdata combinationally (write-first forwarding). The zero-register rule still takes precedence.
- Undefined: reads always return array contents (read-before-write). No forwarding logic is generated.

Decomposition:
- Package regfile_pkg:
  - localparam REG_ZERO = 0.
  - Function clog2-safe NUM_REGS helper.
  - typedef for the wr_count width (16-bit saturating counter max constant 16'hFFFF).
- Sub-module decoder_onehot:
  - Parameter IN_W; ports en, in[IN_W-1:0], out[2**IN_W-1:0].
  - Behaviour: out = en ? (1 << in) : 0.
  - Generalised replacement for the fixed 3-to-8 / 5-to-32 decoders.
- Array, status registers and the bypass mux remain in regfile_decoded.

Test Plan:
- Reset state: assert reset mid-run after writes to r3/r7 -> all rdata 0, wr_onehot_q=0, wr_count_q=0 while reset is high and after release.
- Basic write/read: we=1 waddr=5 wdata=32'hDEADBEEF, then raddr_a=5 next cycle.
  - Expected: rdata_a=32'hDEADBEEF, wr_onehot_q=32'h0000_0020, wr_count_q=1.
  - Following idle cycle: wr_onehot_q=0.
- Zero register: write 32'h12345678 to addr 0 (ZERO_REG_EN=1) -> rdata_a(raddr 0)=0, wr_onehot_q=0, wr_count_q unchanged. With ZERO_REG_EN=0 the read returns 32'h12345678.
- Same-cycle read/write of addr 9 (old 32'h1, new 32'h2):
  - Macro undefined: rdata_a=32'h1 in the write cycle and 32'h2 after.
  - Macro defined: rdata_a=32'h2 in the write cycle.
- Dual port and sweep: write r[i]=i*32'h01010101 for i=1..31, then read every pair (i, 31-i) -> both ports match; wr_count_q=31; exactly one wr_onehot_q bit set per write cycle.
- Parametrisation: ADDR_W=3, DATA_W=8, 70000 accepted writes -> wr_count_q saturates at 16'hFFFF; addresses 0..7 write and read back correctly.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the decoded register file.
// Pure definitions: no latency, no backpressure.
package regfile_pkg;

    localparam int REG_ZERO = 0;

    typedef logic [15:0] wr_count_t;
    localparam wr_count_t WR_COUNT_MAX = 16'hFFFF;

    // Register count for an address width; a zero width still yields one register.
    function automatic int num_regs(input int addr_w);
        return (addr_w < 1) ? 1 : (1 << addr_w);
    endfunction

endpackage

// File: rtl/regfile_decoded_decoder.sv
// N-to-2^N one-hot decoder with enable; purely combinational, zero latency.
// No backpressure: output follows inputs every cycle.
module decoder_onehot #(
    parameter int IN_W = 5
) (
    input  logic                 en,
    input  logic [IN_W-1:0]      in,
    output logic [2**IN_W-1:0]   out
);

    localparam int OUT_W = 2**IN_W;

    always_comb begin
        out = '0;
        if (en) out = OUT_W'(1) << in;
    end

endmodule

// File: rtl/regfile_decoded.sv
// 1W/2R register file with one-hot write decode, zero register and write status; 1-cycle write, 0-cycle read.
// No backpressure: a write is taken every cycle we=1. REGFILE_BYPASS_EN adds write-first forwarding.
module regfile_decoded
    import regfile_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int ZERO_REG_EN = 1,
    localparam int NUM_REGS   = num_regs(ADDR_W)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [ADDR_W-1:0]    raddr_a,
    input  logic [ADDR_W-1:0]    raddr_b,
    output logic [DATA_W-1:0]    rdata_a,
    output logic [DATA_W-1:0]    rdata_b,
    output logic [NUM_REGS-1:0]  wr_onehot_q,
    output logic [15:0]          wr_count_q
);

    logic [NUM_REGS-1:0] onehot;
    logic                zero_hit_w;
    logic                accepted;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    decoder_onehot #(.IN_W(ADDR_W)) u_dec (
        .en  (we),
        .in  (waddr),
        .out (onehot)
    );

    assign zero_hit_w = (ZERO_REG_EN != 0) && (waddr == ADDR_W'(REG_ZERO));
    assign accepted   = we && !zero_hit_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (accepted) begin
            regs[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_onehot_q <= '0;
            wr_count_q  <= '0;
        end else begin
            wr_onehot_q <= onehot & {NUM_REGS{accepted}};
            if (accepted && wr_count_q != WR_COUNT_MAX)
                wr_count_q <= wr_count_q + 16'd1;
        end
    end

    // Zero-register masking is applied last so it overrides forwarding.
    always_comb begin
        rdata_a = regs[raddr_a];
`ifdef REGFILE_BYPASS_EN
        if (accepted && raddr_a == waddr) rdata_a = wdata;
`endif
        if (ZERO_REG_EN != 0 && raddr_a == ADDR_W'(REG_ZERO)) rdata_a = '0;
    end

    always_comb begin
        rdata_b = regs[raddr_b];
`ifdef REGFILE_BYPASS_EN
        if (accepted && raddr_b == waddr) rdata_b = wdata;
`endif
        if (ZERO_REG_EN != 0 && raddr_b == ADDR_W'(REG_ZERO)) rdata_b = '0;
    end

endmodule

// File: tb/tb_regfile_decoded.sv
// Bench for regfile_decoded: directed vectors on three configurations checked against a behavioural model.
module tb_regfile_decoded;

    logic        clk = 1'b0;
    logic        reset, rst_s;
    logic        we;
    logic [4:0]  waddr, raddr_a, raddr_b;
    logic [31:0] wdata;
    logic [31:0] rdata_a, rdata_b, oh, z_rdata_a, z_rdata_b, z_oh;
    logic [15:0] cnt, z_cnt;

    logic        we_s;
    logic [2:0]  waddr_s, raddr_a_s, raddr_b_s;
    logic [7:0]  wdata_s, rdata_a_s, rdata_b_s, oh_s;
    logic [15:0] cnt_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_decoded #(.ADDR_W(5), .DATA_W(32), .ZERO_REG_EN(1)) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .wr_onehot_q(oh), .wr_count_q(cnt)
    );

    regfile_decoded #(.ADDR_W(5), .DATA_W(32), .ZERO_REG_EN(0)) dut_z (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(z_rdata_a), .rdata_b(z_rdata_b),
        .wr_onehot_q(z_oh), .wr_count_q(z_cnt)
    );

    regfile_decoded #(.ADDR_W(3), .DATA_W(8), .ZERO_REG_EN(0)) dut_s (
        .clk(clk), .reset(rst_s), .we(we_s), .waddr(waddr_s), .wdata(wdata_s),
        .raddr_a(raddr_a_s), .raddr_b(raddr_b_s), .rdata_a(rdata_a_s), .rdata_b(rdata_b_s),
        .wr_onehot_q(oh_s), .wr_count_q(cnt_s)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] mm [32];
    logic [31:0] mz [32];
    logic [7:0]  ms [8];
    logic [31:0] moh, zoh;
    logic [7:0]  soh;
    logic [15:0] mcnt, zcnt, scnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) begin
                mm[k] <= '0;
                mz[k] <= '0;
            end
            moh <= '0; mcnt <= '0; zoh <= '0; zcnt <= '0;
        end else begin
            if (we && waddr != 5'd0) begin
                mm[waddr] <= wdata;
                moh <= 32'd1 << waddr;
                mcnt <= sat_inc(mcnt);
            end else begin
                moh <= '0;
            end
            if (we) begin
                mz[waddr] <= wdata;
                zoh <= 32'd1 << waddr;
                zcnt <= sat_inc(zcnt);
            end else begin
                zoh <= '0;
            end
        end
    end

    always @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            for (int k = 0; k < 8; k++) ms[k] <= '0;
            soh <= '0; scnt <= '0;
        end else if (we_s) begin
            ms[waddr_s] <= wdata_s;
            soh <= 8'd1 << waddr_s;
            scnt <= sat_inc(scnt);
        end else begin
            soh <= '0;
        end
    end

    // Expected read: array value, optionally forwarded from this cycle's write, zero register last.
    function automatic logic [31:0] exp_rd(input logic [31:0] stored, input logic [4:0] ra,
                                           input logic w, input logic [4:0] wa,
                                           input logic [31:0] wd, input bit zero_en);
        logic [31:0] d;
        d = stored;
`ifdef REGFILE_BYPASS_EN
        if (w && !(zero_en && wa == 5'd0) && ra == wa) d = wd;
`endif
        if (zero_en && ra == 5'd0) d = '0;
        return d;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("main.rdata_a", rdata_a, exp_rd(mm[raddr_a], raddr_a, we, waddr, wdata, 1'b1));
        chk("main.rdata_b", rdata_b, exp_rd(mm[raddr_b], raddr_b, we, waddr, wdata, 1'b1));
        chk("main.onehot",  oh, moh);
        chk("main.count",   32'(cnt), 32'(mcnt));
        chk("z.rdata_a", z_rdata_a, exp_rd(mz[raddr_a], raddr_a, we, waddr, wdata, 1'b0));
        chk("z.rdata_b", z_rdata_b, exp_rd(mz[raddr_b], raddr_b, we, waddr, wdata, 1'b0));
        chk("z.onehot",  z_oh, zoh);
        chk("z.count",   32'(z_cnt), 32'(zcnt));
        chk("s.rdata_a", 32'(rdata_a_s),
            exp_rd(32'(ms[raddr_a_s]), 5'(raddr_a_s), we_s, 5'(waddr_s), 32'(wdata_s), 1'b0));
        chk("s.rdata_b", 32'(rdata_b_s),
            exp_rd(32'(ms[raddr_b_s]), 5'(raddr_b_s), we_s, 5'(waddr_s), 32'(wdata_s), 1'b0));
        chk("s.onehot",  32'(oh_s), 32'(soh));
        chk("s.count",   32'(cnt_s), 32'(scnt));
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb);
        @(posedge clk);
        #1;
        we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
    endtask

    task automatic main_seq();
        step(1'b1, 5'd3, 32'hA5A5_0003, 5'd3, 5'd7);
        step(1'b1, 5'd7, 32'h0000_0777, 5'd3, 5'd7);
        step(1'b0, 5'd0, 32'h0, 5'd3, 5'd7);
        @(negedge clk);
        chk("lit.r3", rdata_a, 32'hA5A5_0003);
        chk("lit.r7", rdata_b, 32'h0000_0777);
        chk("lit.cnt2", 32'(cnt), 32'd2);

        // reset lands while a write is being presented
        step(1'b1, 5'd4, 32'h0000_FFFF, 5'd3, 5'd7);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("lit.rst_r3", rdata_a, 32'h0);
        chk("lit.rst_r7", rdata_b, 32'h0);
        chk("lit.rst_oh", oh, 32'h0);
        chk("lit.rst_cnt", 32'(cnt), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0; we = 1'b0; raddr_a = 5'd4;
        @(negedge clk);
        chk("lit.post_r4", rdata_a, 32'h0);
        chk("lit.post_r7", rdata_b, 32'h0);
        chk("lit.post_cnt", 32'(cnt), 32'h0);

        step(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        @(negedge clk);
        chk("lit.r5", rdata_a, 32'hDEAD_BEEF);
        chk("lit.r5b", rdata_b, 32'hDEAD_BEEF);
        chk("lit.oh5", oh, 32'h0000_0020);
        chk("lit.cnt1", 32'(cnt), 32'd1);
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        @(negedge clk);
        chk("lit.oh_idle", oh, 32'h0);

        step(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        chk("lit.zero_rd", rdata_a, 32'h0);
        chk("lit.zero_oh", oh, 32'h0);
        chk("lit.zero_cnt", 32'(cnt), 32'd1);
        chk("lit.z_rd", z_rdata_a, 32'h1234_5678);
        chk("lit.z_oh", z_oh, 32'h1);
        chk("lit.z_cnt", 32'(z_cnt), 32'd2);

        step(1'b1, 5'd9, 32'h1, 5'd0, 5'd0);
        step(1'b1, 5'd9, 32'h2, 5'd9, 5'd9);
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        chk("lit.r9_same", rdata_a, 32'h2);
`else
        chk("lit.r9_same", rdata_a, 32'h1);
`endif
        step(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        @(negedge clk);
        chk("lit.r9_after", rdata_a, 32'h2);

        step(1'b0, 5'bxxxxx, 32'hFFFF_FFFF, 5'd5, 5'd9);
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
        @(negedge clk);
        chk("lit.x_r5", rdata_a, 32'hDEAD_BEEF);
        chk("lit.x_r9", rdata_b, 32'h2);

        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 1; i < 32; i++)
            step(1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'(i), 5'(31 - i));
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        chk("lit.sweep_oh", oh, 32'h8000_0000);
        chk("lit.sweep_cnt", 32'(cnt), 32'd31);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            @(negedge clk);
            chk("lit.pair_a", rdata_a, 32'(i) * 32'h0101_0101);
            chk("lit.pair_b", rdata_b, 32'(31 - i) * 32'h0101_0101);
        end
    endtask

    task automatic small_seq();
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            #1;
            we_s = 1'b1; waddr_s = i[2:0]; wdata_s = i[7:0];
            raddr_a_s = 3'(i + 7); raddr_b_s = i[2:0];
        end
        @(posedge clk);
        #1 we_s = 1'b0;
        @(negedge clk);
        chk("lit.s_sat", 32'(cnt_s), 32'h0000_FFFF);
        // last write to address a was i = 69992 + a, whose low byte is 8'h68 + a
        for (int a = 0; a < 8; a++) begin
            @(posedge clk);
            #1 raddr_a_s = 3'(a);
            @(negedge clk);
            chk("lit.s_read", 32'(rdata_a_s), 32'(8'h68 + 8'(a)));
        end
    endtask

    initial begin
        reset = 1'b1; rst_s = 1'b1;
        we = 1'b0; waddr = '0; wdata = '0; raddr_a = 5'd3; raddr_b = 5'd7;
        we_s = 1'b0; waddr_s = '0; wdata_s = '0; raddr_a_s = '0; raddr_b_s = '0;
        @(negedge clk);
        chk("lit.init_a", rdata_a, 32'h0);
        chk("lit.init_oh", oh, 32'h0);
        chk("lit.init_cnt", 32'(cnt), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0; rst_s = 1'b0;
        fork
            main_seq();
            small_seq();
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got no completion expected completion by %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
